// File: rtl/chunked_adder.sv
// Multi-cycle N-bit adder that adds one W-bit slice per clock with a registered carry.
// Optional macro CHUNKED_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module chunked_adder #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
`ifdef CHUNKED_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic [1:0]   dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; in_ready is high only in IDLE outside reset, out_valid only in DONE.

  localparam int S  = N / W;
  localparam int KW = (S > 1) ? $clog2(S) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(S - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;

  logic [N-1:0]  b_eff;
  logic          cin_eff;
  logic [W-1:0]  a_slice;
  logic [W-1:0]  b_slice;
  logic [W:0]    slice_sum;

  // Subtraction is folded into the latched operand: a - b == a + ~b + 1.
  always_comb begin
`ifdef CHUNKED_ADDER_SUB_EN
    b_eff   = sub ? ~b : b;
    cin_eff = sub ? 1'b1 : cin;
`else
    b_eff   = b;
    cin_eff = cin;
`endif
  end

  always_comb begin
    a_slice   = a_q[k_q*W +: W];
    b_slice   = b_q[k_q*W +: W];
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{W{1'b0}}, carry_q};
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b_eff;
          carry_d = cin_eff;
          k_d     = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[k_q*W +: W] = slice_sum[W-1:0];
        carry_d           = slice_sum[W];
        k_d               = k_q + KW'(1);
        if (k_q == K_LAST) begin
          cout_d  = slice_sum[W];
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum         = sum_q;
  assign cout        = cout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed and randomized bench for chunked_adder at N=16/W=4 and N=W=8.
module tb_chunked_adder;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16;
  logic [15:0] a16, b16, sum16;
  logic [1:0]  dbg16;
  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic [1:0]  dbg8;
`ifdef CHUNKED_ADDER_SUB_EN
  logic        sub16, sub8;
`endif

  logic [16:0] exp_q[$];
  logic [8:0]  exp8_q[$];

  chunked_adder #(.N(16), .W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16),
`ifdef CHUNKED_ADDER_SUB_EN
    .sub(sub16),
`endif
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .dbg_state_o(dbg16)
  );

  chunked_adder #(.N(8), .W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8),
`ifdef CHUNKED_ADDER_SUB_EN
    .sub(sub8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .dbg_state_o(dbg8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the 16-bit instance, with bp cycles of backpressure.
  task automatic do_op16(input logic [15:0] oa, input logic [15:0] ob,
                         input logic ocin, input logic osub, input int bp);
    logic [16:0] e;
    int lat;
    lat = 0;
    while (!in_ready16 && lat < 40) begin
      tick;
      lat++;
    end
    chk("ready_before_accept", in_ready16, 1);
    if (osub) e = {1'b0, oa} + {1'b0, ~ob} + 17'd1;
    else      e = {1'b0, oa} + {1'b0, ob} + {16'd0, ocin};
    exp_q.push_back(e);
    a16 = oa; b16 = ob; cin16 = ocin;
`ifdef CHUNKED_ADDER_SUB_EN
    sub16 = osub;
`endif
    in_valid16  = 1'b1;
    out_ready16 = (bp == 0);
    tick;
    // Operands change and in_valid toggles after acceptance; none of it may matter.
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    in_valid16 = 1'($urandom);
    chk("in_ready_busy", in_ready16, 0);
    lat = 0;
    while (!out_valid16 && lat < 40) begin
      tick;
      lat++;
    end
    chk("latency", lat, 4);
    e = exp_q.pop_front();
    chk("sum", sum16, e[15:0]);
    chk("cout", cout16, e[16]);
    for (int i = 0; i < bp; i++) begin
      in_valid16 = 1'($urandom_range(0, 1));
      a16 = 16'($urandom);
      tick;
      chk("hold_valid", out_valid16, 1);
      chk("hold_sum", sum16, e[15:0]);
      chk("hold_cout", cout16, e[16]);
      chk("hold_in_ready", in_ready16, 0);
    end
    in_valid16  = 1'b0;
    out_ready16 = 1'b1;
    tick;
    chk("drain_valid", out_valid16, 0);
    chk("drain_in_ready", in_ready16, 1);
    chk("post_sum", sum16, e[15:0]);
  endtask

  initial begin
    int acc_cyc;
    int last_done;
    logic acc;
    logic [8:0] e8;

    rst = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b1;
`ifdef CHUNKED_ADDER_SUB_EN
    sub16 = 1'b0; sub8 = 1'b0;
`endif
    tick;
    tick;
    chk("rst_in_ready", in_ready16, 0);
    chk("rst_out_valid", out_valid16, 0);
    chk("rst_sum", sum16, 0);
    chk("rst_cout", cout16, 0);
    chk("rst_in_ready8", in_ready8, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready16, 1);

    do_op16(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    do_op16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    do_op16(16'h00FF, 16'h0001, 1'b0, 1'b0, 5);

    // Reset while slice 2 is being processed.
    in_valid16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b0;
    tick;
    in_valid16 = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    chk("midrst_out_valid", out_valid16, 0);
    chk("midrst_sum", sum16, 0);
    chk("midrst_cout", cout16, 0);
    chk("midrst_in_ready", in_ready16, 0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_after", in_ready16, 1);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("midrst_no_pulse", out_valid16, 0);
    end
    do_op16(16'd1, 16'd2, 1'b0, 1'b0, 0);

    for (int i = 0; i < 8; i++)
      do_op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0,
              $urandom_range(0, 3));

`ifdef CHUNKED_ADDER_SUB_EN
    do_op16(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    do_op16(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++)
      do_op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 2));
`endif

    // N=W=8: single-slice latency and back-to-back throughput with in_valid held high.
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    in_valid8 = 1'b1;
    acc_cyc = 0;
    last_done = -1;
    for (int i = 0; i < 13; i++) begin
      acc = in_ready8;
      if (acc) exp8_q.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
      tick;
      if (acc) acc_cyc = cyc;
      if (out_valid8) begin
        e8 = (exp8_q.size() > 0) ? exp8_q.pop_front() : 9'h1FF;
        chk("sum8", sum8, e8[7:0]);
        chk("cout8", cout8, e8[8]);
        chk("lat8", cyc - acc_cyc, 1);
        if (last_done >= 0) chk("period8", cyc - last_done, 3);
        last_done = cyc;
      end
      if (acc) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
    end
    chk("results8_seen", (last_done >= 0), 1);
    in_valid8 = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
